// File: rtl/cachedir_pkg.sv
// Shared encodings for the cache directory controller: request ops, default
// geometry, entry layout and controller states.
package cachedir_pkg;

   localparam int ADDR_WIDTH_DEF = 9;
   localparam int TAG_WIDTH_DEF  = 28;

   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_FILL   = 2'b01;
   localparam logic [1:0] OP_INVAL  = 2'b10;
   localparam logic [1:0] OP_FLUSH  = 2'b11;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      RESP,
      FLUSH
   } state_e;

   // The valid flag sits directly above the tag field in each entry.
   function automatic int valid_pos(input int tag_width);
      return tag_width;
   endfunction

endpackage

// File: rtl/cachedir_ctrl.sv
// Cache directory controller: sweeps RAM port B clear after reset/flush, serves
// lookup/fill/invalidate on port A. Response 1 cycle after accept (flush: depth+1);
// a held response stalls new requests, which pass through on the handshake cycle.
module cachedir_ctrl
   import cachedir_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int TAG_WIDTH  = TAG_WIDTH_DEF
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_index,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_hit,
   output logic [TAG_WIDTH-1:0]  rsp_tag,
   output logic                  init_done,
   output logic                  dir_wren_a,
   output logic [ADDR_WIDTH-1:0] dir_address_a,
   output logic [TAG_WIDTH:0]    dir_data_a,
   input  logic [TAG_WIDTH:0]    dir_q_a,
   output logic                  dir_wren_b,
   output logic [ADDR_WIDTH-1:0] dir_address_b,
   output logic [TAG_WIDTH:0]    dir_data_b
);

   localparam int VB = valid_pos(TAG_WIDTH);

   state_e                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
   logic                    hit_nxt;
   logic [TAG_WIDTH-1:0]    tag_nxt;
   logic                    init_done_nxt;
   logic                    accept;
   logic                    cnt_last;
   logic                    stored_valid;
   logic [TAG_WIDTH-1:0]    stored_tag;
   logic                    tag_hit;

   assign dir_address_a = req_index;
   assign dir_address_b = cnt;
   assign dir_data_b    = '0;
   assign dir_data_a    = (req_op == OP_FILL) ? {1'b1, req_tag} : '0;

   assign stored_valid = dir_q_a[VB];
   assign stored_tag   = dir_q_a[TAG_WIDTH-1:0];
   assign tag_hit      = stored_valid && (stored_tag == req_tag);
   assign cnt_last     = (cnt == '1);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      hit_nxt       = rsp_hit;
      tag_nxt       = rsp_tag;
      init_done_nxt = init_done;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      dir_wren_a    = 1'b0;
      dir_wren_b    = 1'b0;
      accept        = 1'b0;

      case (state)
         INIT: begin
            dir_wren_b = 1'b1;
            cnt_nxt    = cnt + ADDR_WIDTH'(1);
            if (cnt_last) begin
               state_nxt     = IDLE;
               init_done_nxt = 1'b1;
            end
         end
         FLUSH: begin
            dir_wren_b = 1'b1;
            cnt_nxt    = cnt + ADDR_WIDTH'(1);
            if (cnt_last) begin
               state_nxt = RESP;
               hit_nxt   = 1'b0;
               tag_nxt   = '0;
            end
         end
         IDLE: begin
            req_ready = 1'b1;
         end
         RESP: begin
            rsp_valid = 1'b1;
            req_ready = rsp_ready;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = INIT;
      endcase

      // A request accepted on the handshake cycle overrides the return to IDLE.
      accept = req_valid && req_ready;
      if (accept) begin
         case (req_op)
            OP_LOOKUP: begin
               state_nxt = RESP;
               hit_nxt   = tag_hit;
               tag_nxt   = stored_tag;
            end
            OP_FILL: begin
               state_nxt  = RESP;
               hit_nxt    = stored_valid;
               tag_nxt    = stored_tag;
               dir_wren_a = 1'b1;
            end
            OP_INVAL: begin
               state_nxt  = RESP;
               hit_nxt    = tag_hit;
               tag_nxt    = stored_tag;
               dir_wren_a = tag_hit;
            end
            default: begin
               state_nxt = FLUSH;
               hit_nxt   = 1'b0;
               tag_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= INIT;
         cnt       <= '0;
         rsp_hit   <= 1'b0;
         rsp_tag   <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rsp_hit   <= hit_nxt;
         rsp_tag   <= tag_nxt;
         init_done <= init_done_nxt;
      end
   end

endmodule

// File: tb/tb_cachedir_ctrl.sv
// Bench for cachedir_ctrl: behavioural RAM, directory model with a response
// queue, and a per-cycle monitor comparing every response against the model.
module tb_cachedir_ctrl;
   import cachedir_pkg::*;

   localparam int AW    = 9;
   localparam int TW    = 28;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          req_valid, req_ready;
   logic [1:0]    req_op;
   logic [AW-1:0] req_index;
   logic [TW-1:0] req_tag;
   logic          rsp_valid, rsp_ready, rsp_hit;
   logic [TW-1:0] rsp_tag;
   logic          init_done;
   logic          dir_wren_a, dir_wren_b;
   logic [AW-1:0] dir_address_a, dir_address_b;
   logic [TW:0]   dir_data_a, dir_q_a, dir_data_b;

   always #5 clock = ~clock;

   cachedir_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_index(req_index), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_tag(rsp_tag),
      .init_done(init_done),
      .dir_wren_a(dir_wren_a), .dir_address_a(dir_address_a), .dir_data_a(dir_data_a),
      .dir_q_a(dir_q_a),
      .dir_wren_b(dir_wren_b), .dir_address_b(dir_address_b), .dir_data_b(dir_data_b)
   );

   // Directory RAM: combinational read on A, writes land at the clock edge.
   logic [TW:0] mem [DEPTH];
   assign dir_q_a = mem[dir_address_a];
   always @(posedge clock) begin
      if (dir_wren_a) mem[dir_address_a] <= dir_data_a;
      if (dir_wren_b) mem[dir_address_b] <= dir_data_b;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic          hit;
      logic [TW-1:0] tag;
      int            due;
   } exp_t;

   exp_t          exp_q[$];
   bit            mv [DEPTH];
   logic [TW-1:0] mt [DEPTH];
   bit            mon_en = 0;
   int            wb_cnt = 0;

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         mv[i] = 1'b0;
         mt[i] = '0;
      end
   endtask

   // Present one request and keep it until accepted; model computes the response.
   task automatic do_req(input logic [1:0] op, input int idx, input logic [TW-1:0] tag,
                         input logic lhit, input logic [TW-1:0] ltag, output int acc);
      bit            got;
      logic          h, ew;
      logic [TW-1:0] t;
      exp_t          e;
      got       = 0;
      acc       = -1;
      req_op    = op;
      req_index = idx[AW-1:0];
      req_tag   = tag;
      req_valid = 1'b1;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clock);
         if (req_ready) got = 1;
         else begin
            @(posedge clock);
            #1;
         end
      end
      chk("req_accept", got, 1);
      if (got) begin
         acc = cyc;
         if (op == OP_FLUSH) begin
            h  = 1'b0;
            t  = '0;
            ew = 1'b0;
            model_clear();
            e.due = acc + DEPTH + 1;
         end else begin
            h  = (op == OP_FILL) ? mv[idx] : (mv[idx] && mt[idx] == tag);
            t  = mt[idx];
            ew = (op == OP_FILL) || (op == OP_INVAL && h);
            if (op == OP_FILL) begin
               mv[idx] = 1'b1;
               mt[idx] = tag;
            end else if (op == OP_INVAL && h) begin
               mv[idx] = 1'b0;
               mt[idx] = '0;
            end
            e.due = acc + 1;
         end
         e.hit = h;
         e.tag = t;
         exp_q.push_back(e);
         chk("model_hit", h, lhit);
         chk("model_tag", t, ltag);
         chk("dir_wren_a", dir_wren_a, ew);
         if (ew) chk("dir_data_a", dir_data_a, (op == OP_FILL) ? {1'b1, tag} : '0);
         @(posedge clock);
         #1;
      end
   endtask

   task automatic idle();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
         @(posedge clock);
         #1;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // Response monitor: ordering, latency, hold-under-backpressure, port exclusivity.
   logic          prev_v = 0, prev_r = 0, prev_h = 0;
   logic [TW-1:0] prev_t = '0;
   bit            front_seen = 0;
   always @(negedge clock) begin
      if (mon_en) begin
         chk("wren_exclusive", dir_wren_a && dir_wren_b, 0);
         if (dir_wren_b) wb_cnt++;
         if (prev_v && !prev_r) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_hit", rsp_hit, prev_h);
            chk("hold_tag", rsp_tag, prev_t);
         end
         if (exp_q.size() > 0 && !front_seen && cyc == exp_q[0].due)
            chk("rsp_due_valid", rsp_valid, 1);
         if (rsp_valid) begin
            chk("rsp_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               if (!front_seen) begin
                  chk("rsp_latency", cyc, exp_q[0].due);
                  front_seen = 1;
               end
               if (rsp_ready) begin
                  chk("rsp_hit", rsp_hit, exp_q[0].hit);
                  chk("rsp_tag", rsp_tag, exp_q[0].tag);
                  void'(exp_q.pop_front());
                  front_seen = 0;
               end
            end
         end
      end
      prev_v = rsp_valid;
      prev_r = rsp_ready;
      prev_h = rsp_hit;
      prev_t = rsp_tag;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, a0, a1, a2, a3, af, al, wb0;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = OP_LOOKUP;
      req_index = '0;
      req_tag   = '0;
      rsp_ready = 1'b1;

      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (200) @(posedge clock);
      @(negedge clock);
      chk("sweep_mid_addr", dir_address_b, 200);
      reset_n = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_hit", rsp_hit, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_wren_a", dir_wren_a, 0);
      chk("rst_addr_b", dir_address_b, 0);

      @(posedge clock);
      #1 reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clock);
         if (!(dir_wren_b && dir_address_b == AW'(i) && dir_data_b == '0 && !init_done &&
               !req_ready && !rsp_valid && !dir_wren_a)) bad++;
      end
      chk("init_sweep_bad_cycles", bad, 0);
      @(negedge clock);
      chk("init_done_rise", init_done, 1);
      chk("init_req_ready", req_ready, 1);
      chk("init_wren_b_off", dir_wren_b, 0);
      chk("init_rsp_valid", rsp_valid, 0);
      model_clear();
      mon_en = 1;
      @(posedge clock);
      #1;

      do_req(OP_LOOKUP, 5, 28'h0000123, 1'b0, 28'h0, a0);
      do_req(OP_FILL,   5, 28'h00ABCDE, 1'b0, 28'h0, a0);
      do_req(OP_LOOKUP, 5, 28'h00ABCDE, 1'b1, 28'h00ABCDE, a0);
      do_req(OP_LOOKUP, 5, 28'h00ABCDF, 1'b0, 28'h00ABCDE, a0);
      do_req(OP_FILL,   5, 28'h0000011, 1'b1, 28'h00ABCDE, a0);
      do_req(OP_INVAL,  5, 28'h0000012, 1'b0, 28'h0000011, a0);
      do_req(OP_INVAL,  5, 28'h0000011, 1'b1, 28'h0000011, a0);
      do_req(OP_LOOKUP, 5, 28'h0000011, 1'b0, 28'h0, a0);
      idle();
      drain();

      rsp_ready = 1'b0;
      do_req(OP_FILL, 7, 28'h0000077, 1'b0, 28'h0, a0);
      idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_rsp_hit", rsp_hit, 0);
         chk("bp_rsp_tag", rsp_tag, 0);
      end
      @(posedge clock);
      #1 rsp_ready = 1'b1;
      do_req(OP_LOOKUP, 7, 28'h0000077, 1'b1, 28'h0000077, a1);
      do_req(OP_FILL,   7, 28'h0000078, 1'b1, 28'h0000077, a2);
      do_req(OP_LOOKUP, 7, 28'h0000078, 1'b1, 28'h0000078, a3);
      idle();
      chk("b2b_accept_1", a2, a1 + 1);
      chk("b2b_accept_2", a3, a2 + 1);
      drain();

      do_req(OP_FILL, 0,   28'h00000A0, 1'b0, 28'h0, a0);
      do_req(OP_FILL, 511, 28'h00001FF, 1'b0, 28'h0, a0);
      idle();
      drain();
      wb0 = wb_cnt;
      do_req(OP_FLUSH, 0, 28'h0, 1'b0, 28'h0, af);
      do_req(OP_LOOKUP, 0, 28'h00000A0, 1'b0, 28'h0, al);
      chk("flush_blocks_req", al, af + DEPTH + 1);
      do_req(OP_LOOKUP, 511, 28'h00001FF, 1'b0, 28'h0, a0);
      idle();
      drain();
      chk("flush_sweep_cycles", wb_cnt - wb0, DEPTH);
      chk("flush_init_done", init_done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
